// File: rtl/rle_pkg.sv
// Shared types and constants for the run-length encoder.
// Optional statistics outputs are enabled with the RLE_STATS_EN macro
// (see run_length_encoder.sv).
package rle_pkg;

  localparam int RLE_LEN_W_DEF = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rle_state_e;

  // Record as stored in the FIFO: run value in the MSB, length below it.
  typedef struct packed {
    logic                     bit_v;
    logic [RLE_LEN_W_DEF-1:0] len;
  } rle_rec_t;

endpackage

// File: rtl/rle_fifo.sv
// Single-clock record FIFO with asynchronous active-low reset.
// A push while full is accepted only if a pop happens in the same cycle;
// a pop while empty is ignored.
module rle_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  import rle_pkg::*;

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             pop_ok_s;
  logic             push_ok_s;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    pop_ok_s  = pop && (level_q != '0);
    push_ok_s = push && ((level_q != LVL_FULL) || pop_ok_s);
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // FIFO state registers; reset clears storage so the head reads as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);

endmodule

// File: rtl/run_length_encoder.sv
// Run-length encoder: measures constant-value runs of a sampled serial
// stream and queues (bit, length) records behind a valid/ready handshake.
// Define RLE_STATS_EN to add the rec_count / max_len statistics outputs.
module run_length_encoder
  import rle_pkg::*;
#(
  parameter int LEN_W = RLE_LEN_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     bit_in,
  input  logic                     edge_in,
  input  logic                     flush,
  input  logic                     rec_ready,
  output logic                     rec_valid,
  output logic                     rec_bit,
  output logic [LEN_W-1:0]         rec_len,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy,
  output logic                     overflow
`ifdef RLE_STATS_EN
  ,
  output logic [15:0]              rec_count,
  output logic [LEN_W-1:0]         max_len
`endif
);

  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  rle_state_e        state_q, state_d;
  logic              cur_bit_q, cur_bit_d;
  logic [LEN_W-1:0]  run_cnt_q, run_cnt_d;
  logic              overflow_q, overflow_d;
  logic              push_s;
  logic [LEN_W-1:0]  push_len_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic [LEN_W:0]    rdata_s;

  // Run tracking FSM: decides when a run closes and what record it yields.
  always_comb begin
    state_d    = state_q;
    cur_bit_d  = cur_bit_q;
    run_cnt_d  = run_cnt_q;
    push_s     = 1'b0;
    push_len_s = run_cnt_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = IDLE;
        end else if (en) begin
          state_d   = RUN;
          cur_bit_d = bit_in;
          run_cnt_d = LEN_ONE;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (flush) begin
          push_s    = 1'b1;
          state_d   = IDLE;
          run_cnt_d = '0;
        end else if (en) begin
          if (edge_in) begin
            push_s    = 1'b1;
            cur_bit_d = bit_in;
            run_cnt_d = LEN_ONE;
          end else if (run_cnt_q == LEN_MAX) begin
            // Saturated: emit a full-length record and keep counting the same run.
            push_s    = 1'b1;
            run_cnt_d = LEN_ONE;
          end else begin
            run_cnt_d = run_cnt_q + LEN_ONE;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d   = IDLE;
        run_cnt_d = '0;
      end
    endcase
  end

  // A drop happens only when the FIFO is full and nothing leaves this cycle.
  always_comb begin
    overflow_d = overflow_q;
    if (push_s && full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Encoder state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cur_bit_q  <= 1'b0;
      run_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_bit_q  <= cur_bit_d;
      run_cnt_q  <= run_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign pop_s = rec_ready && !empty_s;

  rle_fifo #(
    .WIDTH (LEN_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({cur_bit_q, push_len_s}),
    .rdata (rdata_s),
    .level (fifo_level),
    .full  (full_s),
    .empty (empty_s)
  );

  assign rec_valid = !empty_s;
  assign rec_bit   = rdata_s[LEN_W];
  assign rec_len   = rdata_s[LEN_W-1:0];
  assign busy      = (state_q == RUN);
  assign overflow  = overflow_q;

`ifdef RLE_STATS_EN
  logic              push_ok_s;
  logic [15:0]       rec_count_q, rec_count_d;
  logic [LEN_W-1:0]  max_len_q, max_len_d;

  assign push_ok_s = push_s && (!full_s || pop_s);

  // Statistics: count stored records and track the longest stored length.
  always_comb begin
    rec_count_d = rec_count_q;
    max_len_d   = max_len_q;
    if (push_ok_s) begin
      rec_count_d = rec_count_q + 16'd1;
      if (push_len_s > max_len_q) begin
        max_len_d = push_len_s;
      end else begin
        max_len_d = max_len_q;
      end
    end else begin
      rec_count_d = rec_count_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rec_count_q <= 16'd0;
      max_len_q   <= '0;
    end else begin
      rec_count_q <= rec_count_d;
      max_len_q   <= max_len_d;
    end
  end

  assign rec_count = rec_count_q;
  assign max_len   = max_len_q;
`endif

endmodule

// File: tb/tb_run_length_encoder.sv
// Self-checking bench for run_length_encoder (default build, LEN_W=4, DEPTH=4).
module tb_run_length_encoder;

  localparam int LEN_W = 4;
  localparam int DEPTH = 4;
  localparam int MAXL  = 15;

  logic clk;
  logic rst;
  logic en;
  logic bit_in;
  logic edge_in;
  logic flush;
  logic rec_ready;
  logic rec_valid;
  logic rec_bit;
  logic [LEN_W-1:0] rec_len;
  logic [$clog2(DEPTH):0] fifo_level;
  logic busy;
  logic overflow;

  int checks;
  int failures;

  run_length_encoder #(.LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bit_in     (bit_in),
    .edge_in    (edge_in),
    .flush      (flush),
    .rec_ready  (rec_ready),
    .rec_valid  (rec_valid),
    .rec_bit    (rec_bit),
    .rec_len    (rec_len),
    .fifo_level (fifo_level),
    .busy       (busy),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A run is tracked by its unbounded total length; records are cut every
  // MAXL samples and the remainder (1..MAXL) is emitted when the run closes.
  bit          m_active;
  bit          m_bit;
  int          m_total;
  bit          m_ovf;
  logic [LEN_W:0] mq[$];
  bit          m_do_push;
  logic [LEN_W:0] m_rec;

  function automatic int tail_len(input int total);
    return ((total - 1) % MAXL) + 1;
  endfunction

  always @(negedge rst) begin
    m_active = 1'b0;
    m_total  = 0;
    m_ovf    = 1'b0;
    mq.delete();
  end

  always @(posedge clk) begin
    if (rst) begin
      m_do_push = 1'b0;
      m_rec     = '0;
      if (flush) begin
        if (m_active) begin
          m_do_push = 1'b1;
          m_rec     = {m_bit, LEN_W'(tail_len(m_total))};
          m_active  = 1'b0;
        end
      end else if (en) begin
        if (!m_active) begin
          m_active = 1'b1;
          m_bit    = bit_in;
          m_total  = 1;
        end else if (edge_in) begin
          m_do_push = 1'b1;
          m_rec     = {m_bit, LEN_W'(tail_len(m_total))};
          m_bit     = bit_in;
          m_total   = 1;
        end else begin
          if (m_total % MAXL == 0) begin
            m_do_push = 1'b1;
            m_rec     = {m_bit, LEN_W'(MAXL)};
          end
          m_total = m_total + 1;
        end
      end
      if (mq.size() > 0 && rec_ready) void'(mq.pop_front());
      if (m_do_push) begin
        if (mq.size() < DEPTH) mq.push_back(m_rec);
        else m_ovf = 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("rec_valid", int'(rec_valid), int'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("rec_bit", int'(rec_bit), int'(mq[0][LEN_W]));
        chk("rec_len", int'(rec_len), int'(mq[0][LEN_W-1:0]));
      end
      chk("fifo_level", int'(fifo_level), mq.size());
      chk("busy", int'(busy), int'(m_active));
      chk("overflow", int'(overflow), int'(m_ovf));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic e, input logic b, input logic ed, input logic f, input logic r);
    en = e; bit_in = b; edge_in = ed; flush = f; rec_ready = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    en = 1'b0; bit_in = 1'b0; edge_in = 1'b0; flush = 1'b0; rec_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; en = 1'b0; bit_in = 1'b0; edge_in = 1'b0; flush = 1'b0; rec_ready = 1'b0;
    #1;
    chk("reset rec_valid", int'(rec_valid), 0);
    chk("reset rec_bit", int'(rec_bit), 0);
    chk("reset rec_len", int'(rec_len), 0);
    chk("reset fifo_level", int'(fifo_level), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset overflow", int'(overflow), 0);
    do_reset();

    // 1: three zeros then a one with edge -> {0,3}
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t1 rec_valid", int'(rec_valid), 1);
    chk("t1 rec_bit", int'(rec_bit), 0);
    chk("t1 rec_len", int'(rec_len), 3);
    chk("t1 busy", int'(busy), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 2: twenty ones then flush -> {1,15}, {1,5}
    repeat (20) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2 level", int'(fifo_level), 2);
    chk("t2 head len", int'(rec_len), 15);
    chk("t2 head bit", int'(rec_bit), 1);
    chk("t2 busy", int'(busy), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2 second len", int'(rec_len), 5);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 3: runs of length 1..5 with no drain; fifth record dropped
    for (int r = 1; r <= 5; r++) begin
      for (int k = 0; k < r; k++) begin
        cyc(1'b1, logic'(r % 2 == 0), logic'(k == 0 && r > 1), 1'b0, 1'b0);
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3 level", int'(fifo_level), 4);
    chk("t3 overflow", int'(overflow), 1);
    for (int r = 1; r <= 4; r++) begin
      chk("t3 drain bit", int'(rec_bit), int'(r % 2 == 0));
      chk("t3 drain len", int'(rec_len), r);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("t3 empty", int'(rec_valid), 0);

    // 4: push and pop together while full
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4 full level", int'(fifo_level), 4);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t4 level", int'(fifo_level), 4);
    chk("t4 overflow", int'(overflow), 0);
    chk("t4 head len", int'(rec_len), 1);
    chk("t4 head bit", int'(rec_bit), 1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4 tail bit", int'(rec_bit), 0);
    chk("t4 tail len", int'(rec_len), 3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 5: asynchronous reset mid-run with two queued records
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5 pre level", int'(fifo_level), 2);
    en = 1'b0; edge_in = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t5 async rec_valid", int'(rec_valid), 0);
    chk("t5 async level", int'(fifo_level), 0);
    chk("t5 async busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5 fresh busy", int'(busy), 1);
    chk("t5 fresh level", int'(fifo_level), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5 flush len", int'(rec_len), 1);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 6: flush in IDLE, then flush together with edge after two samples
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6 idle flush level", int'(fifo_level), 0);
    chk("t6 idle flush busy", int'(busy), 0);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t6 level", int'(fifo_level), 1);
    chk("t6 bit", int'(rec_bit), 1);
    chk("t6 len", int'(rec_len), 2);
    chk("t6 busy", int'(busy), 0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_length_encoder.md
# run_length_encoder

Downstream consumer of the serial transition-detect stage. Takes the sampled serial bit plus the one-cycle transition strobe and measures the length of each constant-value run. Completed runs go into a small FIFO as (bit, length) records with a valid/ready output handshake. Feeds framing/statistics logic that needs run lengths rather than raw bits.

## Interface
- LEN_W, 4: run-length field width; maximum encodable run is 2^LEN_W-1.
- DEPTH, 4: record FIFO depth, power of two, at least 2.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  sample strobe; bit_in is consumed on cycles with en=1.
- bit_in  in  1  serial bit, same timing as the upstream detector's input delayed by one register, so that edge_in and the first sample of a new run coincide.
- edge_in  in  1  transition strobe from the upstream detector; 1 means this sample differs from the previous sample.
- flush  in  1  close the current run immediately.
- rec_ready  in  1  downstream accepts the head record.
- rec_valid  out  1  head record present (FIFO not empty).
- rec_bit  out  1  bit value of the head record.
- rec_len  out  LEN_W  run length of the head record, range 1..2^LEN_W-1.
- fifo_level  out  $clog2(DEPTH)+1  number of records held.
- busy  out  1  a run is active (state RUN).
- overflow  out  1  sticky flag: a record was dropped.

## Operation
- FSM states:
  - IDLE: no active run.
  - RUN: cur_bit and run_cnt hold the active run.
- IDLE, en=1: go to RUN with cur_bit=bit_in and run_cnt=1. No record; edge_in is ignored in IDLE.
- RUN, en=1, edge_in=0:
  - run_cnt < max: run_cnt+1.
  - run_cnt == max: push {cur_bit, max} (saturation split) and set run_cnt=1.
- RUN, en=1, edge_in=1: push {cur_bit, run_cnt}, then cur_bit=bit_in, run_cnt=1.
- flush=1 has priority. en, bit_in and edge_in are ignored that cycle.
  - In RUN: push {cur_bit, run_cnt} and go to IDLE.
  - In IDLE: no action.
- At most one push per cycle by construction.
- Pop occurs when rec_valid && rec_ready.
- Push when full and no pop that cycle: the record is dropped and overflow is set. overflow clears only on reset.
- Push and pop in the same cycle while full: both happen; level is unchanged and there is no overflow.
- Push and pop in the same cycle while empty: the new record is stored and level becomes 1. The pop is not performed because rec_valid was 0.
- rec_bit/rec_len are driven directly from the head storage entry and are stable while rec_valid=1 && rec_ready=0.

## Timing
- Reset values: rec_valid=0, rec_bit=0, rec_len=0, fifo_level=0, busy=0, overflow=0; FSM in IDLE, run_cnt=0, FIFO pointers 0.
- Asserting rst mid-run discards the active run and all queued records at once, without waiting for a clock edge.
- Push latency: the record is written at the rising edge ending the edge/flush/saturation cycle. rec_valid is high in the following cycle.
- fifo_level and busy update at the same edge as the push/pop/state change.
- The pop takes effect at the edge where rec_valid && rec_ready; the next head appears in the following cycle.

## Configuration
- RLE_STATS_EN defined:
  - Adds output rec_count (16 bits), reset 0.
  - Increments on every successful push (dropped records are not counted) and wraps at 2^16.
  - Adds output max_len (LEN_W bits), reset 0, holding the largest rec_len pushed.
- RLE_STATS_EN undefined: neither port exists and no counter logic is built.

## Structure
- Package rle_pkg:
  - state enum (IDLE, RUN).
  - record typedef {bit, len} parameterised by LEN_W default.
  - RLE_LEN_W_DEF constant.
- Sub-module rle_fifo: synchronous single-clock FIFO.
  - Ports: push, pop, wdata, rdata, level, full, empty.
  - Reset asynchronous, active-low.
  - Encoder top holds the FSM, run counter, overflow flag and optional stats.

## Test plan
- Reset; en=1, rec_ready=1; bit_in=0 for 3 samples; then bit_in=1 with edge_in=1. Expect record {0,3}, rec_valid high one cycle after the edge cycle; busy=1.
- LEN_W=4: bit_in=1 for 20 samples with no edge; then flush. Expect records {1,15} then {1,5}; busy=0 after flush.
- rec_ready=0; complete 5 runs of lengths 1..5. Expect fifo_level=4 holding {len 1..4}, fifth run dropped, overflow=1. Drain: records pop in order.
- FIFO full; same cycle push and rec_ready=1. Expect fifo_level stays 4, overflow stays 0, new record at tail.
- Mid-run with 2 queued records, pulse rst low asynchronously. Expect rec_valid=0, fifo_level=0, busy=0 immediately. The first sample after release starts a fresh run with no record.
- flush in IDLE gives no record. flush and edge_in in the same cycle with run_cnt=2 gives a single record {cur_bit,2}, then IDLE.
